// File: rtl/sum_window_reader_pkg.sv
// Shared types and widths for the window-average reader and its counter.
package sum_window_reader_pkg;

  localparam int SUM_W        = 16;
  localparam int SAMPLE_W     = 9;
  localparam int LOG2_WIN_MAX = 7;

  typedef enum logic [1:0] {
    ST_CLR     = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_LATCH   = 2'd3
  } sw_state_e;

endpackage

// File: rtl/sum_window_reader_counter.sv
// Samples-per-window counter: wraps to zero on the increment that hits the terminal count.
module window_counter #(
  parameter int LOG2_WIN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic last_o
);

  // A 0-bit counter is illegal, so LOG2_WIN=0 keeps one bit that never leaves zero.
  localparam int CNT_W = (LOG2_WIN > 0) ? LOG2_WIN : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'((1 << LOG2_WIN) - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign last_o = (count_q == TERM);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = last_o ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sum_window_reader.sv
// Sequences the accumulator through clear/collect/settle/latch windows and presents the
// window average on a valid/ready output with a sticky overrun flag.
module sum_window_reader
  import sum_window_reader_pkg::*;
#(
  parameter int LOG2_WIN = 3
) (
  input  logic                MHz10,
  input  logic                rst,
  input  logic                en,
  input  logic                sample_strobe,
  input  logic [SUM_W-1:0]    current_sum,
  output logic                acc_accumulate,
  output logic                acc_clear,
  output logic [SAMPLE_W-1:0] avg_sample,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic                overrun,
  output sw_state_e           dbg_state
);

  // Handshake: a result transfers on every cycle where avg_valid && avg_ready; the
  // producer never drops avg_valid or changes avg_sample before that transfer, except
  // when a new window latches over an unconsumed result, which raises overrun.

  sw_state_e           state_q, state_d;
  logic [SAMPLE_W-1:0] avg_q, avg_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                cnt_inc, cnt_clr, cnt_last;
  logic                accept;

  window_counter #(.LOG2_WIN(LOG2_WIN)) u_cnt (
    .clk_i  (MHz10),
    .rst_i  (rst),
    .en_i   (en),
    .inc_i  (cnt_inc),
    .clr_i  (cnt_clr),
    .last_o (cnt_last)
  );

  assign accept = valid_q & avg_ready;

  always_comb begin
    state_d        = state_q;
    avg_d          = avg_q;
    valid_d        = valid_q & ~accept;
    ovr_d          = ovr_q;
    acc_accumulate = 1'b0;
    acc_clear      = 1'b0;
    cnt_inc        = 1'b0;
    cnt_clr        = 1'b0;
    // Gating on rst keeps the strobes quiet while reset is held.
    if (en && !rst) begin
      case (state_q)
        ST_CLR: begin
          acc_clear = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = ST_COLLECT;
          if (sample_strobe) ovr_d = 1'b1;
        end
        ST_COLLECT: begin
          if (sample_strobe) begin
            acc_accumulate = 1'b1;
            cnt_inc        = 1'b1;
            if (cnt_last) state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          state_d = ST_LATCH;
          if (sample_strobe) ovr_d = 1'b1;
        end
        ST_LATCH: begin
          acc_clear = 1'b1;
          avg_d     = SAMPLE_W'(current_sum >> LOG2_WIN);
          valid_d   = 1'b1;
          state_d   = ST_COLLECT;
          if (sample_strobe || (valid_q && !avg_ready)) ovr_d = 1'b1;
        end
        default: state_d = ST_CLR;
      endcase
    end
  end

  always_ff @(posedge MHz10) begin
    if (rst) begin
      state_q <= ST_CLR;
      avg_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign avg_sample = avg_q;
  assign avg_valid  = valid_q;
  assign overrun    = ovr_q;
  assign dbg_state  = state_q;

endmodule
